// File: rtl/dram_stream_pkg.sv
// Shared widths and the word-select helper for the DRAM-to-pixel stream path.
package dram_stream_pkg;

  localparam int DRAM_PHRASE_W = 128;
  localparam int PIXEL_W       = 16;

  // Upper bounds that let one helper serve every width combination.
  localparam int MAX_IN_W  = 1024;
  localparam int MAX_OUT_W = 64;
  localparam int SEL_W     = $clog2(MAX_IN_W);
  localparam int OSEL_W    = $clog2(MAX_OUT_W);

  // Picks word idx out of a chunk as a plain bit-select mux. With msb_first
  // set, word 0 is the most significant out_w bits of a ratio-word chunk.
  function automatic logic [MAX_OUT_W-1:0] word_sel(
    input logic [MAX_IN_W-1:0] data,
    input int unsigned         idx,
    input int unsigned         ratio,
    input int unsigned         out_w,
    input logic                msb_first
  );
    int unsigned          sel;
    logic [MAX_OUT_W-1:0] r;
    r   = '0;
    sel = msb_first ? (ratio - 1 - idx) : idx;
    for (int b = 0; b < MAX_OUT_W; b++) begin
      if (b < out_w) r[OSEL_W'(b)] = data[SEL_W'(sel * out_w + b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/unstacker_gen_if.sv
// Chunk-in / pixel-out stream bundle for the width down-converter.
//
// Handshake: both streams use AXI-stream valid/ready. A beat transfers on a
// rising edge where valid and ready are both high. A source holds valid and
// its payload stable until that transfer. A sink may raise or drop ready at
// any time, and ready may depend combinationally on the sink's own inputs.
interface unstacker_gen_if
  import dram_stream_pkg::*;
#(
  parameter int IN_W  = DRAM_PHRASE_W,
  parameter int OUT_W = PIXEL_W
);
  localparam int IDX_W = $clog2(IN_W / OUT_W);

  logic             chunk_tvalid;
  logic             chunk_tready;
  logic [IN_W-1:0]  chunk_tdata;
  logic             chunk_tlast;
  logic [IDX_W-1:0] chunk_tcount;

  logic             pixel_tvalid;
  logic             pixel_tready;
  logic [OUT_W-1:0] pixel_tdata;
  logic             pixel_tlast;

  // Upstream/downstream environment view.
  modport master (
    output chunk_tvalid, chunk_tdata, chunk_tlast, chunk_tcount,
    input  chunk_tready,
    input  pixel_tvalid, pixel_tdata, pixel_tlast,
    output pixel_tready
  );

  // Unstacker view.
  modport slave (
    input  chunk_tvalid, chunk_tdata, chunk_tlast, chunk_tcount,
    output chunk_tready,
    output pixel_tvalid, pixel_tdata, pixel_tlast,
    input  pixel_tready
  );
endinterface

// File: rtl/unstacker_slot.sv
// One chunk holding register (data, count, last, valid) with load and clear.
module unstacker_slot
  import dram_stream_pkg::*;
#(
  parameter int DATA_W = DRAM_PHRASE_W,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CNT_W-1:0]  d_count,
  input  logic              d_last,
  output logic [DATA_W-1:0] q_data,
  output logic [CNT_W-1:0]  q_count,
  output logic              q_last,
  output logic              q_valid
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  // Load wins over clear; clear only drops valid and leaves the payload.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = d_data;
      count_d = d_count;
      last_d  = d_last;
      valid_d = 1'b1;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  // Slot register; reset empties the slot and zeroes the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign q_data  = data_q;
  assign q_count = count_q;
  assign q_last  = last_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/unstacker_gen.sv
// Width down-converter: IN_W-bit chunks in, OUT_W-bit words out, with a
// current slot feeding the output mux and a one-deep prefetch slot behind it.
module unstacker_gen
  import dram_stream_pkg::*;
#(
  parameter int IN_W      = DRAM_PHRASE_W,
  parameter int OUT_W     = PIXEL_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  unstacker_gen_if.slave  bus,
  output logic            busy
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = $clog2(RATIO);

  logic [IN_W-1:0]  cur_data, pend_data, cur_d_data;
  logic [IDX_W-1:0] cur_count, pend_count, cur_d_count, in_count;
  logic             cur_last, pend_last, cur_d_last;
  logic             cur_valid, pend_valid;
  logic             cur_load, cur_clear, cur_from_pend, pend_load, pend_clear;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             accept_in, accept_out, end_word;

  assign accept_out = cur_valid & bus.pixel_tready;
  assign end_word   = accept_out & (idx_q == cur_count);
  // A full pend slot frees up in the same cycle the current chunk retires.
  assign bus.chunk_tready = ~pend_valid | end_word;
  assign accept_in  = bus.chunk_tvalid & bus.chunk_tready;

  // Out-of-range counts only exist for non-power-of-2 ratios; clamp to full.
  always_comb begin
    in_count = bus.chunk_tcount;
    if (32'(bus.chunk_tcount) > RATIO - 1) in_count = IDX_W'(RATIO - 1);
  end

  // Sequencing: advance the word index, retire chunks and route new ones.
  always_comb begin
    idx_d         = idx_q;
    cur_load      = 1'b0;
    cur_clear     = 1'b0;
    cur_from_pend = 1'b0;
    pend_load     = 1'b0;
    pend_clear    = 1'b0;
    if (end_word) begin
      idx_d = '0;
      if (pend_valid) begin
        cur_load      = 1'b1;
        cur_from_pend = 1'b1;
        if (accept_in) pend_load = 1'b1;
        else           pend_clear = 1'b1;
      end else if (accept_in) begin
        cur_load = 1'b1;
      end else begin
        cur_clear = 1'b1;
      end
    end else begin
      if (accept_out) idx_d = idx_q + IDX_W'(1);
      if (!cur_valid && accept_in) begin
        cur_load = 1'b1;
        idx_d    = '0;
      end else if (cur_valid && accept_in) begin
        pend_load = 1'b1;
      end
    end
  end

  // Current slot source: the prefetched chunk when present, else the input.
  always_comb begin
    cur_d_data  = bus.chunk_tdata;
    cur_d_count = in_count;
    cur_d_last  = bus.chunk_tlast;
    if (cur_from_pend) begin
      cur_d_data  = pend_data;
      cur_d_count = pend_count;
      cur_d_last  = pend_last;
    end
  end

  // Word index within the current chunk.
  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  unstacker_slot #(.DATA_W(IN_W), .CNT_W(IDX_W)) u_cur (
    .clk     (clk),
    .rst     (rst),
    .load    (cur_load),
    .clear   (cur_clear),
    .d_data  (cur_d_data),
    .d_count (cur_d_count),
    .d_last  (cur_d_last),
    .q_data  (cur_data),
    .q_count (cur_count),
    .q_last  (cur_last),
    .q_valid (cur_valid)
  );

  unstacker_slot #(.DATA_W(IN_W), .CNT_W(IDX_W)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .load    (pend_load),
    .clear   (pend_clear),
    .d_data  (bus.chunk_tdata),
    .d_count (in_count),
    .d_last  (bus.chunk_tlast),
    .q_data  (pend_data),
    .q_count (pend_count),
    .q_last  (pend_last),
    .q_valid (pend_valid)
  );

  // Outputs come only from registered state, never from chunk_* inputs.
  assign bus.pixel_tvalid = cur_valid;
  assign bus.pixel_tdata  = OUT_W'(word_sel(MAX_IN_W'(cur_data), 32'(idx_q),
                                            RATIO, OUT_W, MSB_FIRST));
  assign bus.pixel_tlast  = cur_valid & cur_last & (idx_q == cur_count);
  assign busy             = cur_valid | pend_valid;

endmodule

// File: tb/tb_unstacker_gen.sv
// Bench for unstacker_gen: default 128->16 LSB-first instance checked every
// cycle against a word-queue model, plus a 64->8 MSB-first instance.
module tb_unstacker_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit done     = 1'b0;

  unstacker_gen_if #(.IN_W(128), .OUT_W(16)) bus0 ();
  unstacker_gen_if #(.IN_W(64),  .OUT_W(8))  bus1 ();

  unstacker_gen #(.IN_W(128), .OUT_W(16), .MSB_FIRST(1'b0)) d0 (
    .clk (clk), .rst (rst), .bus (bus0.slave), .busy (busy0)
  );
  unstacker_gen #(.IN_W(64), .OUT_W(8), .MSB_FIRST(1'b1)) d1 (
    .clk (clk), .rst (rst), .bus (bus1.slave), .busy (busy1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // entry = {word[15:0], tlast, end_of_chunk}
  logic [17:0] exp_q[$];
  int          inflight = 0;      // chunks held by the block (0..2)
  logic [15:0] out_data_q[$];
  bit          out_last_q[$];
  int          out_cyc_q[$];
  int          in_cyc_q[$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    logic        acc_in, acc_out, front_eoc;
    logic [17:0] e;
    int          cnt;
    cyc++;
    if (rst) begin
      exp_q.delete();
      inflight   = 0;
      prev_stall = 1'b0;
    end else begin
      acc_out   = bus0.pixel_tvalid && bus0.pixel_tready;
      acc_in    = bus0.chunk_tvalid && bus0.chunk_tready;
      front_eoc = (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
      chk("pixel_tvalid", bus0.pixel_tvalid, inflight > 0);
      chk("busy", busy0, inflight > 0);
      chk("chunk_tready", bus0.chunk_tready, (inflight < 2) || (acc_out && front_eoc));
      if (bus0.pixel_tvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", bus0.pixel_tdata);
        end else begin
          chk("pixel_tdata", bus0.pixel_tdata, exp_q[0][17:2]);
          chk("pixel_tlast", bus0.pixel_tlast, exp_q[0][1]);
        end
      end
      if (prev_stall) begin
        chk("stall_valid", bus0.pixel_tvalid, 1);
        chk("stall_data", bus0.pixel_tdata, prev_data);
        chk("stall_last", bus0.pixel_tlast, prev_last);
      end
      prev_stall = bus0.pixel_tvalid && !bus0.pixel_tready;
      prev_data  = bus0.pixel_tdata;
      prev_last  = bus0.pixel_tlast;
      if (acc_out) begin
        out_data_q.push_back(bus0.pixel_tdata);
        out_last_q.push_back(bus0.pixel_tlast);
        out_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e[0]) inflight--;
        end
      end
      if (acc_in) begin
        cnt = int'(bus0.chunk_tcount);
        for (int i = 0; i <= cnt; i++)
          exp_q.push_back({bus0.chunk_tdata[i*16 +: 16], bus0.chunk_tlast && (i == cnt), i == cnt});
        inflight++;
        in_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    out_data_q.delete(); out_last_q.delete(); out_cyc_q.delete(); in_cyc_q.delete();
  endtask

  // Presents a chunk and returns just after the edge that accepted it,
  // leaving tvalid high so consecutive calls stream back-to-back.
  task automatic send_chunk(input logic [127:0] data, input logic [2:0] cnt, input logic last);
    int w = 0;
    bus0.chunk_tvalid = 1'b1;
    bus0.chunk_tdata  = data;
    bus0.chunk_tcount = cnt;
    bus0.chunk_tlast  = last;
    do begin
      @(negedge clk);
      w++;
    end while (!bus0.chunk_tready && w < 2000);
    if (!bus0.chunk_tready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no ready expected ready within 2000 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus0.chunk_tvalid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    idle();
    do begin
      @(negedge clk);
      w++;
    end while (busy0 && w < 5000);
    if (busy0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] mk_chunk(input logic [7:0] hi);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = {hi, 8'(i)};
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] c;
    logic [2:0]   rc;
    int           exp_words;
    int           n_last;
    int           w;

    bus0.chunk_tvalid = 0; bus0.chunk_tdata = '0; bus0.chunk_tlast = 0;
    bus0.chunk_tcount = '0; bus0.pixel_tready = 1;
    bus1.chunk_tvalid = 0; bus1.chunk_tdata = '0; bus1.chunk_tlast = 0;
    bus1.chunk_tcount = '0; bus1.pixel_tready = 1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", bus0.pixel_tvalid, 0);
    chk("rst_tlast", bus0.pixel_tlast, 0);
    chk("rst_tdata", bus0.pixel_tdata, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_tready", bus0.chunk_tready, 1);
    chk("rst_tready_d1", bus1.chunk_tready, 1);
    @(posedge clk); #1;

    // T1: four full chunks streamed, tlast on the fourth.
    clear_logs();
    for (int k = 1; k <= 4; k++) send_chunk(mk_chunk(8'(k)), 3'd7, k == 4);
    drain();
    chk("t1_count", out_data_q.size(), 32);
    if (out_data_q.size() == 32) begin
      chk("t1_contig", out_cyc_q[31] - out_cyc_q[0], 31);
      chk("t1_latency", out_cyc_q[0] - in_cyc_q[0], 1);
      chk("t1_w0", out_data_q[0], 16'h0100);
      chk("t1_w9", out_data_q[9], 16'h0201);
      chk("t1_w31", out_data_q[31], 16'h0407);
      chk("t1_last31", out_last_q[31], 1);
      n_last = 0;
      foreach (out_last_q[i]) n_last += int'(out_last_q[i]);
      chk("t1_nlast", n_last, 1);
    end

    // T2: single-word chunks, one per cycle.
    clear_logs();
    for (int k = 1; k <= 4; k++) send_chunk({{7{16'hbeef}}, 16'(16'h0011 * k)}, 3'd0, 1'b0);
    drain();
    chk("t2_count", out_data_q.size(), 4);
    if (out_data_q.size() == 4 && in_cyc_q.size() == 4) begin
      chk("t2_w0", out_data_q[0], 16'h0011);
      chk("t2_w1", out_data_q[1], 16'h0022);
      chk("t2_w2", out_data_q[2], 16'h0033);
      chk("t2_w3", out_data_q[3], 16'h0044);
      chk("t2_out_contig", out_cyc_q[3] - out_cyc_q[0], 3);
      chk("t2_in_contig", in_cyc_q[3] - in_cyc_q[0], 3);
    end

    // T3: partial tail chunk.
    clear_logs();
    for (int i = 0; i < 8; i++) c[i*16 +: 16] = 16'(i + 1);
    send_chunk(c, 3'd2, 1'b1);
    drain();
    chk("t3_count", out_data_q.size(), 3);
    if (out_data_q.size() == 3) begin
      chk("t3_w0", out_data_q[0], 16'd1);
      chk("t3_w2", out_data_q[2], 16'd3);
      chk("t3_last1", out_last_q[1], 0);
      chk("t3_last2", out_last_q[2], 1);
    end

    // T4: MSB-first 64->8 instance.
    bus1.chunk_tvalid = 1; bus1.chunk_tdata = 64'h0102030405060708;
    bus1.chunk_tcount = 3'd7; bus1.chunk_tlast = 1;
    @(negedge clk);
    chk("t4_accept", bus1.chunk_tready, 1);
    @(posedge clk); #1;
    bus1.chunk_tvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_valid", bus1.pixel_tvalid, 1);
      chk("t4_data", bus1.pixel_tdata, 8'(i + 1));
      chk("t4_last", bus1.pixel_tlast, i == 7);
    end
    @(negedge clk);
    chk("t4_done", bus1.pixel_tvalid, 0);
    @(posedge clk); #1;

    // T5: random valid/ready over 1000 chunks.
    clear_logs();
    exp_words = 0;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          while ($urandom_range(0, 1) == 1) begin
            idle();
            @(posedge clk); #1;
          end
          c  = {$urandom, $urandom, $urandom, $urandom};
          rc = 3'($urandom_range(0, 7));
          exp_words += int'(rc) + 1;
          send_chunk(c, rc, $urandom_range(0, 3) == 0);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus0.pixel_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus0.pixel_tready = 1'b1;
    drain();
    chk("t5_words", out_data_q.size(), exp_words);
    chk("t5_exp_empty", exp_q.size(), 0);

    // T6: reset with idx=3 and pend full, then a clean chunk.
    send_chunk(mk_chunk(8'hA0), 3'd7, 1'b1);
    send_chunk(mk_chunk(8'hB0), 3'd7, 1'b1);
    idle();
    w = 0;
    while (bus0.pixel_tdata !== 16'hA003 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("t6_at_idx3", bus0.pixel_tdata, 16'hA003);
    chk("t6_pend_full", bus0.chunk_tready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_tvalid", bus0.pixel_tvalid, 0);
    chk("t6_tlast", bus0.pixel_tlast, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_tready", bus0.chunk_tready, 1);
    @(posedge clk); #1;
    clear_logs();
    send_chunk(mk_chunk(8'hC0), 3'd7, 1'b1);
    drain();
    chk("t6_count", out_data_q.size(), 8);
    if (out_data_q.size() == 8) begin
      chk("t6_w0", out_data_q[0], 16'hC000);
      chk("t6_w7", out_data_q[7], 16'hC007);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
